// File: rtl/div_issue_ctrl.sv
// Issue/complete sequencer for the shared iterative divider.
// Drains the divider after a flush because it cannot be aborted.
module div_issue_ctrl #(
  parameter int LATENCY   = 34,
  parameter int TMO_SLACK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_quotient,
  output logic [31:0] rsp_remainder,
  output logic        rsp_dbz,
  output logic        busy,
  output logic        err_timeout,
  output logic [1:0]  div_op,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [63:0] div_result,
  input  logic        div_done
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP, DRAIN
  } state_t;

  localparam logic [5:0] TMO = 6'(LATENCY + TMO_SLACK);

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic        op_signed;
  logic        dbz;
  logic [31:0] quot, rem;
  logic        dbz_q;
  logic        err;
  logic        accept;
  logic        tmo;
  logic        waiting;

  assign accept  = (state == IDLE) && req_valid && !flush;
  assign waiting = (state == WAIT) || (state == DRAIN);
  assign tmo     = waiting && (cnt >= TMO) && !div_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = ISSUE;
      ISSUE: state_nx = flush ? DRAIN : WAIT;
      WAIT: begin
        if (div_done)   state_nx = flush ? IDLE : RESP;
        else if (tmo)   state_nx = IDLE;
        else if (flush) state_nx = DRAIN;
      end
      RESP:  if (flush || rsp_ready) state_nx = IDLE;
      DRAIN: if (div_done || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == IDLE) && !flush;
    busy          = (state != IDLE);
    rsp_valid     = (state == RESP);
    div_op        = 2'b00;
    if (state == ISSUE) div_op = op_signed ? 2'b10 : 2'b01;
    rsp_quotient  = quot;
    rsp_remainder = rem;
    rsp_dbz       = dbz_q;
    err_timeout   = err;
  end

  // Operands stay on the divider ports until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_dividend <= '0;
      div_divisor  <= '0;
      op_signed    <= 1'b0;
      dbz          <= 1'b0;
      cnt          <= '0;
      quot         <= '0;
      rem          <= '0;
      dbz_q        <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (accept) begin
        div_dividend <= req_dividend;
        div_divisor  <= req_divisor;
        op_signed    <= req_signed;
        dbz          <= (req_divisor == '0);
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (waiting && cnt != 6'h3f)
        cnt <= cnt + 6'd1;
      if (state == WAIT && div_done && !flush) begin
        quot  <= div_result[31:0];
        rem   <= div_result[63:32];
        dbz_q <= dbz;
      end
      if (tmo) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: divider stub, timeline model, directed tests.
// The model tracks transactions by issue timestamp rather than a counter.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_signed = 1'b0;
  logic [31:0] req_dividend = '0;
  logic [31:0] req_divisor = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_quotient;
  logic [31:0] rsp_remainder;
  logic        rsp_dbz;
  logic        busy;
  logic        err_timeout;
  logic [1:0]  div_op;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [63:0] div_result;
  logic        div_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int opcnt = 0;
  bit rv_seen = 0;
  bit stub_hang = 0;

  div_issue_ctrl dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .busy(busy), .err_timeout(err_timeout),
    .div_op(div_op), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_result(div_result),
    .div_done(div_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] divide(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic s);
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider stub: done drops on div_op and returns LATENCY edges later.
  int rem_edges = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_done   <= 1'b1;
      div_result <= '0;
      rem_edges  <= 0;
    end else if (div_op != 2'b00) begin
      div_done   <= 1'b0;
      div_result <= divide(div_dividend, div_divisor, div_op == 2'b10);
      rem_edges  <= stub_hang ? 0 : 34;
    end else if (rem_edges > 0) begin
      if (rem_edges == 1) div_done <= 1'b1;
      rem_edges <= rem_edges - 1;
    end
  end

  // Model: 0 idle, 1 issuing, 2 running, 3 draining, 4 holding result.
  int          m_mode = 0;
  int          t_issue = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_s = 1'b0;
  logic [63:0] m_res = '0;
  logic        m_dbz = 1'b0;
  logic        m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_err  = 1'b0;
      m_res  = '0;
      m_dbz  = 1'b0;
    end else begin
      int age;
      age = cyc - t_issue - 1;
      case (m_mode)
        0: if (req_valid && !flush) begin
          m_mode = 1;
          m_a = req_dividend;
          m_b = req_divisor;
          m_s = req_signed;
        end
        1: begin
          t_issue = cyc;
          m_mode = flush ? 3 : 2;
        end
        2: begin
          if (div_done) begin
            if (flush) m_mode = 0;
            else begin
              m_mode = 4;
              m_res = divide(m_a, m_b, m_s);
              m_dbz = (m_b == 0);
            end
          end else if (age >= 38) begin
            m_err = 1'b1;
            m_mode = 0;
          end else if (flush) m_mode = 3;
        end
        3: begin
          if (div_done) m_mode = 0;
          else if (age >= 38) begin
            m_err = 1'b1;
            m_mode = 0;
          end
        end
        4: if (flush || rsp_ready) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", req_ready, m_mode == 0 && !flush);
      chk("busy", busy, m_mode != 0);
      chk("rsp_valid", rsp_valid, m_mode == 4);
      chk("div_op", div_op,
          m_mode == 1 ? (m_s ? 2'b10 : 2'b01) : 2'b00);
      chk("err_timeout", err_timeout, m_err);
      if (m_mode == 1) begin
        chk("div_dividend", div_dividend, m_a);
        chk("div_divisor", div_divisor, m_b);
      end
      if (m_mode == 4) begin
        chk("rsp_dbz", rsp_dbz, m_dbz);
        if (!m_dbz) begin
          chk("rsp_quotient", rsp_quotient, m_res[31:0]);
          chk("rsp_remainder", rsp_remainder, m_res[63:32]);
        end
      end
      if (div_op != 2'b00) opcnt++;
      if (rsp_valid) rv_seen = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, output int t);
    req_valid = 1'b1;
    req_dividend = a;
    req_divisor = b;
    req_signed = s;
    t = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int tv);
    tv = -1;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin
        tv = cyc;
        break;
      end
      step();
    end
    chk("rsp_wait", tv >= 0, 1);
  endtask

  int t, tv;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_div_op", div_op, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_dividend", div_dividend, 0);
    rst = 1'b0;
    step();

    // 1: DIVU 10/3
    issue(32'd10, 32'd3, 1'b0, t);
    wait_valid(tv);
    chk("t1_latency", tv - t, 37);
    chk("t1_q", rsp_quotient, 3);
    chk("t1_r", rsp_remainder, 1);
    chk("t1_dbz", rsp_dbz, 0);
    step();
    chk("t1_ready", req_ready, 1);

    // 2: DIV -7/2
    opcnt = 0;
    issue(32'hFFFFFFF9, 32'd2, 1'b1, t);
    wait_valid(tv);
    chk("t2_q", rsp_quotient, 32'hFFFFFFFD);
    chk("t2_r", rsp_remainder, 32'hFFFFFFFF);
    step();
    chk("t2_opcnt", opcnt, 1);

    // 3: flush mid-wait, drain, then accept at T+37
    rv_seen = 0;
    issue(32'd100, 32'd7, 1'b0, t);
    while (cyc < t + 10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      step();
    end
    chk("t3_drain_end", cyc - t, 37);
    chk("t3_no_rsp", rv_seen, 0);
    issue(32'd100, 32'd7, 1'b0, t);
    wait_valid(tv);
    chk("t3_q", rsp_quotient, 14);
    chk("t3_r", rsp_remainder, 2);
    step();

    // 4: back-pressure for 5 cycles
    rsp_ready = 1'b0;
    issue(32'd1000, 32'd7, 1'b0, t);
    wait_valid(tv);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_valid", rsp_valid, 1);
      chk("t4_q", rsp_quotient, 142);
      chk("t4_r", rsp_remainder, 6);
      chk("t4_dbz", rsp_dbz, 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_released", rsp_valid, 0);
    chk("t4_idle", busy, 0);

    // 5: divide by zero, then flush beats a request
    issue(32'd5, 32'd0, 1'b0, t);
    wait_valid(tv);
    chk("t5_dbz", rsp_dbz, 1);
    step();
    flush = 1'b1;
    req_valid = 1'b1;
    req_divisor = 32'd9;
    #1;
    chk("t5_flush_ready", req_ready, 0);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("t5_not_busy", busy, 0);
    chk("t5_no_op", div_op, 0);
    step();

    // 6: async reset mid-wait, then a hung divider
    issue(32'd50, 32'd5, 1'b0, t);
    while (cyc < t + 20) step();
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_div_op", div_op, 0);
    chk("t6_dividend", div_dividend, 0);
    chk("t6_divisor", div_divisor, 0);
    chk("t6_q", rsp_quotient, 0);
    chk("t6_r", rsp_remainder, 0);
    chk("t6_dbz", rsp_dbz, 0);
    chk("t6_err", err_timeout, 0);
    step();
    rst = 1'b0;
    step();
    stub_hang = 1;
    issue(32'd50, 32'd5, 1'b0, t);
    for (int i = 0; i < 100; i++) begin
      if (err_timeout) break;
      step();
    end
    chk("t6_tmo_at", cyc - t, 41);
    chk("t6_tmo_err", err_timeout, 1);
    chk("t6_tmo_idle", busy, 0);
    repeat (3) step();
    chk("t6_sticky", err_timeout, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
